// File: rtl/tt_um_semaforo.sv
// Two-street traffic-light controller with parade-mode override (TinyTapeout tile).
// Street A and street B lights are decoded from a 4-state Moore FSM; parade mode
// (flag m_q) holds street B on green. The yellow phases are timed by an up-counter.
module tt_um_semaforo #(
   parameter int YELLOW_CYCLES = 5
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] ui_in,
   output logic [7:0] uo_out,
   input  logic [7:0] uio_in,
   output logic [7:0] uio_out,
   output logic [7:0] uio_oe,
   input  logic       ena
);

   localparam int TW = $clog2(YELLOW_CYCLES + 1);
   localparam logic [TW-1:0] T_LAST = TW'(YELLOW_CYCLES - 1);

   localparam logic [1:0] GREEN  = 2'b00;
   localparam logic [1:0] YELLOW = 2'b01;
   localparam logic [1:0] RED    = 2'b10;

   typedef enum logic [1:0] {
      S0_A_GREEN  = 2'd0,
      S1_A_YELLOW = 2'd1,
      S2_B_GREEN  = 2'd2,
      S3_B_YELLOW = 2'd3
   } state_t;

   state_t         state_q, state_d;
   logic           m_q, m_d;
   logic [TW-1:0]  timer_q, timer_d;
   logic [1:0]     la, lb;

   logic ta, tb, p, r;
   assign ta = ui_in[0];
   assign tb = ui_in[1];
   assign p  = ui_in[2];
   assign r  = ui_in[3];

   // Pins that the tile provides but this block never looks at.
   logic unused_pins;
   assign unused_pins = &{1'b0, ui_in[7:4], uio_in, ena};

   // Next-state logic: mode flag (R beats P), light sequencing and yellow timer.
   always_comb begin
      m_d     = m_q;
      state_d = state_q;
      timer_d = timer_q;

      if (r) begin
         m_d = 1'b0;
      end else if (p) begin
         m_d = 1'b1;
      end

      unique case (state_q)
         S0_A_GREEN: begin
            if (!ta) begin
               state_d = S1_A_YELLOW;
               timer_d = '0;
            end
         end
         S1_A_YELLOW: begin
            if (timer_q == T_LAST) begin
               state_d = S2_B_GREEN;
               timer_d = '0;
            end else begin
               timer_d = timer_q + TW'(1);
            end
         end
         S2_B_GREEN: begin
            // Uses the registered mode flag, so a P pulse only matters from the next cycle.
            if (!tb && !m_q) begin
               state_d = S3_B_YELLOW;
               timer_d = '0;
            end
         end
         S3_B_YELLOW: begin
            if (timer_q == T_LAST) begin
               state_d = S0_A_GREEN;
               timer_d = '0;
            end else begin
               timer_d = timer_q + TW'(1);
            end
         end
         default: begin
            state_d = S0_A_GREEN;
            timer_d = '0;
         end
      endcase
   end

   // State, mode flag and timer registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S0_A_GREEN;
         m_q     <= 1'b0;
         timer_q <= '0;
      end else begin
         state_q <= state_d;
         m_q     <= m_d;
         timer_q <= timer_d;
      end
   end

   // Light decode from the state register only; never drives 2'b11 or two non-reds.
   always_comb begin
      la = RED;
      lb = RED;
      unique case (state_q)
         S0_A_GREEN:  begin la = GREEN;  lb = RED;    end
         S1_A_YELLOW: begin la = YELLOW; lb = RED;    end
         S2_B_GREEN:  begin la = RED;    lb = GREEN;  end
         S3_B_YELLOW: begin la = RED;    lb = YELLOW; end
         default:     begin la = RED;    lb = RED;    end
      endcase
   end

   assign uo_out  = {3'b000, m_q, lb, la};
   assign uio_out = 8'h00;
   assign uio_oe  = 8'h00;

endmodule

// File: tb/tb_tt_um_semaforo.sv
// Self-checking bench for tt_um_semaforo: directed scenarios plus randomized
// traffic, all compared against a phase/countdown reference model.
module tb_tt_um_semaforo;

   localparam int YC = 5;

   logic       clk;
   logic       rst_n;
   logic [7:0] ui_in;
   logic [7:0] uo_out;
   logic [7:0] uio_in;
   logic [7:0] uio_out;
   logic [7:0] uio_oe;
   logic       ena;

   int checks = 0;
   int errors = 0;

   // Reference model: phase 0..3 = A green, A yellow, B green, B yellow.
   int phase = 0;
   int yl    = 0;
   bit mm    = 0;

   tt_um_semaforo #(.YELLOW_CYCLES(YC)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .ui_in   (ui_in),
      .uo_out  (uo_out),
      .uio_in  (uio_in),
      .uio_out (uio_out),
      .uio_oe  (uio_oe),
      .ena     (ena)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [7:0] exp_uo();
      logic [1:0] la, lb;
      la = (phase == 0) ? 2'b00 : (phase == 1) ? 2'b01 : 2'b10;
      lb = (phase == 2) ? 2'b00 : (phase == 3) ? 2'b01 : 2'b10;
      return {3'b000, mm, lb, la};
   endfunction

   task automatic model_reset();
      phase = 0;
      yl    = 0;
      mm    = 0;
   endtask

   task automatic model_update(input logic [7:0] v);
      bit m_old;
      m_old = mm;
      if (v[3]) mm = 0;
      else if (v[2]) mm = 1;
      case (phase)
         0: if (!v[0]) begin phase = 1; yl = YC; end
         1: begin yl--; if (yl == 0) phase = 2; end
         2: if (!v[1] && !m_old) begin phase = 3; yl = YC; end
         default: begin yl--; if (yl == 0) phase = 0; end
      endcase
   endtask

   // Drive one cycle of input, advance the model at the edge, return 1 time unit later.
   task automatic step(input logic [7:0] v);
      ui_in = v;
      @(posedge clk);
      model_update(v);
      #1;
   endtask

   // Safety invariant on every cycle out of reset.
   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         checks++;
         if (uo_out[1:0] !== 2'b10 && uo_out[3:2] !== 2'b10 ||
             uo_out[1:0] === 2'b11 || uo_out[3:2] === 2'b11 || uo_out[7:5] !== 3'b000) begin
            errors++;
            $display("FAIL invariant t=%0t: uo_out=%b", $time, uo_out);
         end
      end
   end

   task automatic test_reset();
      rst_n = 1'b0;
      ui_in = 8'($urandom);
      #3;
      checks++;
      if (uo_out !== 8'h08 || uio_out !== 8'h00 || uio_oe !== 8'h00) begin
         errors++;
         $display("FAIL reset: uo_out=%h uio_out=%h uio_oe=%h expected 08 00 00", uo_out, uio_out, uio_oe);
      end
      model_reset();
      @(negedge clk);
      ui_in = 8'h01;
      rst_n = 1'b1;
   endtask

   task automatic test_street_a_hold();
      for (int i = 0; i < 10; i++) begin
         step(8'h01);
         checks++;
         if (uo_out !== 8'h08) begin
            errors++;
            $display("FAIL a_hold cyc %0d: uo_out=%h expected 08", i, uo_out);
         end
      end
      for (int i = 0; i < YC; i++) begin
         step(8'h00);
         checks++;
         if (uo_out[3:0] !== 4'b1001) begin
            errors++;
            $display("FAIL a_yellow cyc %0d: LB,LA=%b expected 1001", i, uo_out[3:0]);
         end
      end
      step(8'h00);
      checks++;
      if (uo_out[3:0] !== 4'b0010) begin
         errors++;
         $display("FAIL a_to_b: LB,LA=%b expected 0010", uo_out[3:0]);
      end
   endtask

   task automatic test_full_rotation();
      logic [3:0] want;
      int pos;
      @(negedge clk);
      rst_n = 1'b0;
      ui_in = 8'h00;
      #1;
      model_reset();
      rst_n = 1'b1;
      for (int c = 0; c <= 24; c++) begin
         if (c > 0) step(8'h00);
         pos  = c % (2 + 2 * YC);
         want = (pos == 0)      ? 4'b1000 :
                (pos <= YC)     ? 4'b1001 :
                (pos == YC + 1) ? 4'b0010 : 4'b0110;
         checks++;
         if (uo_out[3:0] !== want || uo_out !== exp_uo()) begin
            errors++;
            $display("FAIL rotation c=%0d: uo_out=%h expected LB,LA=%b model=%h", c, uo_out, want, exp_uo());
         end
      end
   endtask

   task automatic test_street_b_hold();
      for (int i = 0; i < 1 + YC; i++) step(8'h02);
      for (int i = 0; i < 10; i++) begin
         step(8'h02);
         checks++;
         if (uo_out[3:0] !== 4'b0010) begin
            errors++;
            $display("FAIL b_hold cyc %0d: LB,LA=%b expected 0010", i, uo_out[3:0]);
         end
      end
      for (int i = 0; i < YC; i++) begin
         step(8'h00);
         checks++;
         if (uo_out[3:0] !== 4'b0110) begin
            errors++;
            $display("FAIL b_yellow cyc %0d: LB,LA=%b expected 0110", i, uo_out[3:0]);
         end
      end
      step(8'h01);
      checks++;
      if (uo_out[3:0] !== 4'b1000) begin
         errors++;
         $display("FAIL b_to_a: LB,LA=%b expected 1000", uo_out[3:0]);
      end
   endtask

   task automatic test_parade();
      step(8'h04);
      checks++;
      if (uo_out[4] !== 1'b1) begin
         errors++;
         $display("FAIL parade_on: on=%b expected 1", uo_out[4]);
      end
      for (int i = 0; i < YC + 10; i++) begin
         step(8'h00);
         checks++;
         if (uo_out !== exp_uo()) begin
            errors++;
            $display("FAIL parade_run cyc %0d: uo_out=%h expected %h", i, uo_out, exp_uo());
         end
      end
      checks++;
      if (uo_out !== 8'h12) begin
         errors++;
         $display("FAIL parade_hold: uo_out=%h expected 12", uo_out);
      end
      step(8'h08);
      checks++;
      if (uo_out !== 8'h02) begin
         errors++;
         $display("FAIL parade_off: uo_out=%h expected 02", uo_out);
      end
      for (int i = 0; i < YC; i++) begin
         step(8'h00);
         checks++;
         if (uo_out !== 8'h06) begin
            errors++;
            $display("FAIL parade_yellow cyc %0d: uo_out=%h expected 06", i, uo_out);
         end
      end
      step(8'h01);
      checks++;
      if (uo_out !== 8'h08) begin
         errors++;
         $display("FAIL parade_end: uo_out=%h expected 08", uo_out);
      end
   endtask

   task automatic test_simultaneous();
      step(8'h05);
      checks++;
      if (uo_out[4] !== 1'b1) begin
         errors++;
         $display("FAIL simul_setup: on=%b expected 1", uo_out[4]);
      end
      step(8'h0D);
      checks++;
      if (uo_out[4] !== 1'b0 || uo_out !== exp_uo()) begin
         errors++;
         $display("FAIL simul_pr: uo_out=%h expected %h", uo_out, exp_uo());
      end
      step(8'h0D);
      checks++;
      if (uo_out[4] !== 1'b0) begin
         errors++;
         $display("FAIL simul_pr_idle: on=%b expected 0", uo_out[4]);
      end
   endtask

   task automatic test_random();
      logic [7:0] v;
      for (int i = 0; i < 400; i++) begin
         v    = 8'($urandom);
         v[0] = ($urandom_range(0, 3) != 0);
         v[1] = ($urandom_range(0, 2) == 0);
         v[2] = ($urandom_range(0, 19) == 0);
         v[3] = ($urandom_range(0, 14) == 0);
         uio_in = 8'($urandom);
         ena    = 1'($urandom);
         step(v);
         checks++;
         if (uo_out !== exp_uo()) begin
            errors++;
            $display("FAIL random cyc %0d in=%h: uo_out=%h expected %h", i, v, uo_out, exp_uo());
         end
      end
   endtask

   task automatic test_async_reset_mid();
      int n;
      n = 0;
      while (phase != 2 && n < 40) begin
         step(8'h02);
         n++;
      end
      checks++;
      if (uo_out[3:2] !== 2'b00 || phase != 2) begin
         errors++;
         $display("FAIL async_setup: LB=%b expected 00 (model phase %0d)", uo_out[3:2], phase);
      end
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (uo_out !== 8'h08) begin
         errors++;
         $display("FAIL async_reset: uo_out=%h expected 08 before any edge", uo_out);
      end
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      step(8'h01);
      checks++;
      if (uo_out !== 8'h08) begin
         errors++;
         $display("FAIL post_reset_hold: uo_out=%h expected 08", uo_out);
      end
      step(8'h00);
      checks++;
      if (uo_out !== 8'h09) begin
         errors++;
         $display("FAIL post_reset_go: uo_out=%h expected 09", uo_out);
      end
   endtask

   initial begin
      rst_n  = 1'b0;
      ui_in  = 8'h00;
      uio_in = 8'h00;
      ena    = 1'b1;
      test_reset();
      test_street_a_hold();
      test_full_rotation();
      test_street_b_hold();
      test_parade();
      test_simultaneous();
      test_random();
      test_async_reset_mid();
      @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
